plt_config_loader: RTL

PLT_CONFIG_LOADER -- requirements
Module: plt_config_loader

---
 rtl/plt_pkg.sv | 10 +
 rtl/plt_cfg_shifter.sv | 31 +++
 rtl/plt_config_loader.sv | 98 +++++++++
 3 files changed

// File: rtl/plt_pkg.sv
// plt_pkg: PLT mode encodings, the config-loader state type and the state-to-mode mapping.
package plt_pkg;
  localparam logic [1:0] MODE_CFG  = 2'b00;
  localparam logic [1:0] MODE_USE  = 2'b01;
  localparam logic [1:0] MODE_TEST = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_VERIFY, ST_RUN} state_e;
  function automatic logic [1:0] mode_of(state_e s);
    return s == ST_RUN ? MODE_USE : s == ST_VERIFY ? MODE_TEST : MODE_CFG;
  endfunction
endpackage

// File: rtl/plt_cfg_shifter.sv
// plt_cfg_shifter: parallel-load, LSB-first right-shift register with a bit counter and last-bit flag.
module plt_cfg_shifter #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         sout,
  output logic         last_bit
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    sr_d  = load ? din : shift ? sr_q >> 1 : sr_q;
    cnt_d = load ? '0 : shift ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end
  assign sout     = sr_q[0];
  assign last_bit = cnt_q == CW'(W - 1);
endmodule

// File: rtl/plt_config_loader.sv
// plt_config_loader: accepts a parallel word and shifts it LSB-first into a PLT, then switches it to usage mode.
// Build option PLT_CFG_READBACK_EN adds a two-cycle VERIFY (test mode) comparing scan_rd against a shadow copy.
module plt_config_loader
  import plt_pkg::*;
#(
  parameter  int N     = 8,
  localparam int CFG_W = 4 * (N - 1)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [CFG_W-1:0] cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             config_in,
  output logic             cfg_shift,
  output logic [1:0]       mode,
  input  logic [CFG_W-1:0] scan_rd,
  output logic             done,
  output logic             error
);
  state_e     state_q, state_d;
  logic       cfg_ready_q, cfg_ready_d;
  logic       cfg_shift_q, cfg_shift_d;
  logic       done_q, done_d;
  logic [1:0] mode_q, mode_d;
  logic       hs, sout, last_bit;
  assign hs = cfg_valid & cfg_ready_q;
  plt_cfg_shifter #(.W(CFG_W)) u_shifter (
    .clk      (clk),
    .clear_n  (clear_n),
    .load     (hs),
    .shift    (state_q == ST_SHIFT),
    .din      (cfg_data),
    .sout     (sout),
    .last_bit (last_bit)
  );
`ifdef PLT_CFG_READBACK_EN
  localparam state_e SHIFT_EXIT = ST_VERIFY;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic             phase_q, phase_d;
  logic             error_q, error_d;
  always_comb begin
    shadow_d = hs ? cfg_data : shadow_q;
    phase_d  = state_q == ST_VERIFY && !phase_q;
    error_d  = hs ? 1'b0 : (state_q == ST_VERIFY && phase_q && scan_rd != shadow_q) ? 1'b1 : error_q;
  end
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      shadow_q <= '0;
      phase_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      phase_q  <= phase_d;
      error_q  <= error_d;
    end
  end
  assign error = error_q;
`else
  localparam state_e SHIFT_EXIT = ST_RUN;
  logic unused_scan;
  assign unused_scan = ^scan_rd;
  assign error       = 1'b0;
`endif
  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    state_d = state_q;
    if (hs) state_d = ST_SHIFT;
    else if (state_q == ST_SHIFT && last_bit) state_d = SHIFT_EXIT;
`ifdef PLT_CFG_READBACK_EN
    else if (state_q == ST_VERIFY && phase_q) state_d = scan_rd == shadow_q ? ST_RUN : ST_IDLE;
`endif
    cfg_ready_d = state_d == ST_IDLE || state_d == ST_RUN;
    cfg_shift_d = state_d == ST_SHIFT;
    mode_d      = mode_of(state_d);
    done_d      = state_d == ST_RUN && state_q != ST_RUN;
  end
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= ST_IDLE;
      cfg_ready_q <= 1'b0;
      cfg_shift_q <= 1'b0;
      mode_q      <= MODE_CFG;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_shift_q <= cfg_shift_d;
      mode_q      <= mode_d;
      done_q      <= done_d;
    end
  end
  assign cfg_ready = cfg_ready_q;
  assign cfg_shift = cfg_shift_q;
  assign config_in = cfg_shift_q & sout;
  assign mode      = mode_q;
  assign done      = done_q;
endmodule
